// File: rtl/xm23_pkg.sv
// xm23_pkg: shared types and constants for the register-file writeback stage
//    reg_idx_t  : 3-bit register index
//    gprc_t     : register-read view, bank 0 = GPRs, bank 1 = constant table
//    wb_entry_t : pending write held between capture and commit
//    CONST_TABLE: read-only bank 1 contents, index 0 in the low element
package xm23_pkg;
   typedef logic [2:0] reg_idx_t;
   typedef logic [1:0][7:0][15:0] gprc_t;
   typedef struct packed {
      logic        valid;
      reg_idx_t    dst;
      logic        byte_en;
      logic [15:0] val;
   } wb_entry_t;
   localparam logic [7:0][15:0] CONST_TABLE = {16'hFFFF, 16'd32, 16'd16, 16'd8,
                                               16'd4, 16'd2, 16'd1, 16'd0};
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: execute-stage write request, pipeline control and forwarding bus
//    wb_valid_i/wb_dst_i/wb_byte_i/wb_val_i : write request from execute
//    stall_i/flush_i                         : pipeline control
//    fwd_valid_o/fwd_dst_o/fwd_val_o         : pending write forwarded to earlier stages
//    master drives the request side, slave is the writeback stage
interface regfile_writeback_if;
   import xm23_pkg::*;
   logic        wb_valid_i;
   reg_idx_t    wb_dst_i;
   logic        wb_byte_i;
   logic [15:0] wb_val_i;
   logic        stall_i;
   logic        flush_i;
   logic        fwd_valid_o;
   reg_idx_t    fwd_dst_o;
   logic [15:0] fwd_val_o;
   modport master (output wb_valid_i, wb_dst_i, wb_byte_i, wb_val_i, stall_i, flush_i,
                   input  fwd_valid_o, fwd_dst_o, fwd_val_o);
   modport slave  (input  wb_valid_i, wb_dst_i, wb_byte_i, wb_val_i, stall_i, flush_i,
                   output fwd_valid_o, fwd_dst_o, fwd_val_o);
endinterface

// File: rtl/regfile_writeback_merge.sv
// wb_merge: byte-write merge, a byte write replaces only bits [7:0]
//    old_val : current register contents
//    new_val : write data
//    byte_en : 1 selects byte write, 0 selects full word write
//    merged  : value to be written
module wb_merge (
   input  logic [15:0] old_val,
   input  logic [15:0] new_val,
   input  logic        byte_en,
   output logic [15:0] merged
);
   assign merged = byte_en ? {old_val[15:8], new_val[7:0]} : new_val;
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: two-step writeback register and GPR array with constant bank
//    clk, rst  : clock, asynchronous active-high reset
//    wb        : write request, stall/flush and forwarding outputs (slave side)
//    gprc      : bank 0 GPRs, bank 1 constant table, to the register-read stage
//    pc_load_o : one-cycle pulse after a commit to R7
//    WB_BYPASS_EN : when defined, the pending write shows in gprc one edge early
module regfile_writeback
   import xm23_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   regfile_writeback_if.slave   wb,
   output gprc_t                gprc,
   output logic                 pc_load_o
);
   logic [7:0][15:0] regs;
   wb_entry_t        pend;
   logic [15:0]      merged;

   // one merge serves both the commit and the forwarded value, so they can never disagree
   wb_merge u_merge (
      .old_val (regs[pend.dst]),
      .new_val (pend.val),
      .byte_en (pend.byte_en),
      .merged  (merged)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs      <= '0;
         pend      <= '0;
         pc_load_o <= 1'b0;
      end else begin
         pc_load_o <= 1'b0;
         if (wb.flush_i) begin
            pend.valid <= 1'b0;
         end else if (!wb.stall_i) begin
            if (pend.valid) begin
               regs[pend.dst] <= merged;
               pc_load_o      <= pend.dst == 3'd7;
            end
            pend <= '{valid: wb.wb_valid_i, dst: wb.wb_dst_i, byte_en: wb.wb_byte_i, val: wb.wb_val_i};
         end
      end
   end

   assign wb.fwd_valid_o = pend.valid;
   assign wb.fwd_dst_o   = pend.valid ? pend.dst : '0;
   assign wb.fwd_val_o   = pend.valid ? merged : '0;

`ifdef WB_BYPASS_EN
   always_comb begin
      gprc[1] = CONST_TABLE;
      gprc[0] = regs;
      if (pend.valid && !wb.stall_i) gprc[0][pend.dst] = merged;
   end
`else
   assign gprc = {CONST_TABLE, regs};
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: randomized and directed checks against a behavioural register-file model
module tb_regfile_writeback;
   import xm23_pkg::*;
   logic  clk = 1'b0;
   logic  rst = 1'b1;
   gprc_t gprc;
   logic  pc_load;
   int    checks = 0;
   int    failures = 0;
   logic [15:0] m_reg [8];
   bit          p_v;
   int          p_d;
   bit          p_b;
   logic [15:0] p_val;
   bit          exp_pc;
   logic [15:0] consts [8] = '{16'd0, 16'd1, 16'd2, 16'd4, 16'd8, 16'd16, 16'd32, 16'hFFFF};

   regfile_writeback_if bus ();
   regfile_writeback dut (.clk(clk), .rst(rst), .wb(bus), .gprc(gprc), .pc_load_o(pc_load));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] m_merge(input int d);
      return p_b ? ((m_reg[d] & 16'hFF00) | (p_val & 16'h00FF)) : p_val;
   endfunction

   task automatic m_clear();
      foreach (m_reg[i]) m_reg[i] = 16'h0;
      p_v = 0; p_d = 0; p_b = 0; p_val = 16'h0; exp_pc = 0;
   endtask

   task automatic model_edge();
      exp_pc = 0;
      if (rst) m_clear();
      else if (bus.flush_i) p_v = 0;
      else if (!bus.stall_i) begin
         if (p_v) begin
            m_reg[p_d] = m_merge(p_d);
            exp_pc = (p_d == 7);
         end
         p_v = bus.wb_valid_i; p_d = int'(bus.wb_dst_i); p_b = bus.wb_byte_i; p_val = bus.wb_val_i;
      end
   endtask

   task automatic check_all();
      logic [15:0] e;
      for (int i = 0; i < 8; i++) begin
         e = m_reg[i];
`ifdef WB_BYPASS_EN
         if (p_v && !bus.stall_i && p_d == i) e = m_merge(i);
`endif
         chk($sformatf("gpr%0d", i), 32'(gprc[0][i]), 32'(e));
         chk($sformatf("const%0d", i), 32'(gprc[1][i]), 32'(consts[i]));
      end
      chk("pc_load", 32'(pc_load), 32'(exp_pc));
      chk("fwd_valid", 32'(bus.fwd_valid_o), 32'(p_v));
      chk("fwd_dst", 32'(bus.fwd_dst_o), p_v ? 32'(p_d) : 32'd0);
      chk("fwd_val", 32'(bus.fwd_val_o), p_v ? 32'(m_merge(p_d)) : 32'd0);
   endtask

   task automatic step(input logic v, input logic [2:0] d, input logic b, input logic [15:0] val,
                       input logic st, input logic fl, input logic r);
      @(negedge clk);
      bus.wb_valid_i = v; bus.wb_dst_i = d; bus.wb_byte_i = b; bus.wb_val_i = val;
      bus.stall_i = st; bus.flush_i = fl; rst = r;
      @(posedge clk);
      model_edge();
      #1 check_all();
   endtask

   task automatic idle();
      step(0, 3'd0, 0, 16'h0, 0, 0, 0);
   endtask

   initial begin
      bus.wb_valid_i = 0; bus.wb_dst_i = '0; bus.wb_byte_i = 0; bus.wb_val_i = '0;
      bus.stall_i = 0; bus.flush_i = 0;
      m_clear();
      step(0, 3'd0, 0, 16'h0, 0, 0, 1);
      step(1, 3'd5, 0, 16'hDEAD, 0, 0, 1);
      chk("rst_fwd_valid", 32'(bus.fwd_valid_o), 32'd0);
      idle();
      // word write R3
      step(1, 3'd3, 0, 16'h1234, 0, 0, 0);
      chk("r3_fwd_val", 32'(bus.fwd_val_o), 32'h1234);
      idle();
      chk("r3_word", 32'(gprc[0][3]), 32'h1234);
      // byte write R2 keeps the high byte
      step(1, 3'd2, 0, 16'hABCD, 0, 0, 0);
      step(1, 3'd2, 1, 16'h0077, 0, 0, 0);
      idle();
      chk("r2_byte", 32'(gprc[0][2]), 32'hAB77);
      // back-to-back writes to R1
      step(1, 3'd1, 0, 16'h0000, 0, 0, 0);
      step(1, 3'd1, 1, 16'h0011, 0, 0, 0);
      step(1, 3'd1, 1, 16'h0022, 0, 0, 0);
      idle();
      chk("r1_b2b_byte", 32'(gprc[0][1]), 32'h0022);
      step(1, 3'd1, 0, 16'h5566, 0, 0, 0);
      step(1, 3'd1, 1, 16'h0099, 0, 0, 0);
      idle();
      chk("r1_word_byte", 32'(gprc[0][1]), 32'h5599);
      // stall holds the pending R4 write
      step(1, 3'd4, 0, 16'hBEEF, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 3'd6, 0, 16'h1111, 1, 0, 0);
         chk("r4_stalled", 32'(gprc[0][4]), 32'h0);
         chk("r4_fwd_hold", 32'(bus.fwd_val_o), 32'hBEEF);
      end
      idle();
      chk("r4_after_stall", 32'(gprc[0][4]), 32'hBEEF);
      // flush beats stall
      step(1, 3'd5, 0, 16'h5555, 0, 0, 0);
      step(1, 3'd6, 0, 16'h6666, 1, 1, 0);
      idle();
      idle();
      chk("r5_flushed", 32'(gprc[0][5]), 32'h0);
      chk("r6_flushed", 32'(gprc[0][6]), 32'h0);
      // PC pulse on R7 commit
      step(1, 3'd7, 0, 16'h0100, 0, 0, 0);
`ifdef WB_BYPASS_EN
      chk("r7_bypass_early", 32'(gprc[0][7]), 32'h0100);
`endif
      idle();
      chk("pc_pulse", 32'(pc_load), 32'd1);
      chk("r7_word", 32'(gprc[0][7]), 32'h0100);
      idle();
      chk("pc_pulse_end", 32'(pc_load), 32'd0);
      // asynchronous reset with a write pending
      step(1, 3'd6, 0, 16'h6666, 0, 0, 0);
      @(negedge clk);
      rst = 1;
      #1;
      m_clear();
      check_all();
      step(0, 3'd0, 0, 16'h0, 0, 0, 1);
      idle();
      chk("r6_discarded", 32'(gprc[0][6]), 32'h0);
      // randomized traffic
      for (int n = 0; n < 400; n++)
         step(1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(1)), 16'($urandom),
              $urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(49) == 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have the port wb_valid_i, input, 1 bit: the execute stage presents a register write this cycle.
REQ-004 SHALL have the port wb_dst_i, input, 3 bits: destination register R0..R7, bank 0 only.
REQ-005 SHALL have the port wb_byte_i, input, 1 bit: 1 means byte write, where only bits [7:0] are replaced.
REQ-006 SHALL have the port wb_val_i, input, 16 bits: write data.
REQ-007 SHALL have the port stall_i, input, 1 bit: pipeline stall; hold the pending write and ignore the inputs.
REQ-008 SHALL have the port flush_i, input, 1 bit: discard the pending write without committing it.
REQ-009 SHALL have the port gprc, output, [1:0][7:0][15:0]: bank 0 is the GPRs and bank 1 is the constant table, feeding the register-read stage.
REQ-010 SHALL have the port pc_load_o, output, 1 bit: a one-cycle pulse when a commit targets R7.
REQ-011 SHALL have the port fwd_valid_o, output, 1 bit: a pending write is held in the WB register.
REQ-012 SHALL have the port fwd_dst_o, output, 3 bits: the destination of the pending write.
REQ-013 SHALL have the port fwd_val_o, output, 16 bits: the fully merged 16-bit value the pending write will commit.

Function
REQ-014 SHALL be a two-step path: the capture edge loads the WB register {valid, dst, byte, val}, and the next edge commits it to the array; latency from input to gprc visible is 2 edges.
REQ-015 SHALL capture at an edge when stall_i=0 and flush_i=0: WB.valid<=wb_valid_i, and dst/byte/val are loaded.
REQ-016 SHALL commit at an edge when WB.valid=1, stall_i=0 and flush_i=0, with the committed value reg[dst] <= byte ? {reg[dst][15:8], val[7:0]} : val.
REQ-017 SHALL perform the commit and the next capture in the same edge, so back-to-back writes sustain one write per cycle.
REQ-018 SHALL compute the byte merge of a back-to-back write to the same register from the array value updated by the previous commit, so no byte is lost.
REQ-019 SHALL, with stall_i=1, leave the WB register and the array unchanged, hold the fwd_* outputs, and keep pc_load_o=0.
REQ-020 SHALL, with flush_i=1, clear WB.valid at the edge and commit nothing; flush_i takes priority over stall_i.
REQ-021 SHALL assert pc_load_o for exactly the cycle following the edge on which a commit to R7 occurred.
REQ-022 SHALL hold gprc bank 1 constant as {0,1,2,4,8,16,32,0xFFFF} for indices 0..7; it is never writable.
REQ-023 SHALL make fwd_val_o apply the same byte-merge rule as the commit, merging against the current array value.
REQ-024 SHALL drive the fwd_* outputs to zero whenever WB.valid=0.

Reset
REQ-025 SHALL, while rst=1, immediately clear bank 0 R0..R7 to 0x0000.
REQ-026 SHALL, while rst=1, immediately clear WB.valid to 0.
REQ-027 SHALL, while rst=1, immediately drive pc_load_o to 0.
REQ-028 SHALL, while rst=1, immediately drive the fwd_* outputs to 0.
REQ-029 SHALL make a reset asserted mid-operation discard the pending write, so it is never committed.
REQ-030 SHALL resume capture on the first rising edge after rst deasserts.

Configuration
REQ-031 SHALL, when WB_BYPASS_EN is defined, drive gprc bank 0 entry fwd_dst_o with fwd_val_o whenever fwd_valid_o=1 and stall_i=0, making a write readable 1 edge after capture.
REQ-032 SHALL, when WB_BYPASS_EN is not defined, drive gprc bank 0 purely from the committed array; the fwd_* outputs remain functional.

Structure
REQ-033 SHALL place the following in shared package xm23_pkg:
- the constant-table localparam (8x16);
- a typedef for register index (3 bits);
- a typedef for the gprc type [1:0][7:0][15:0];
- a packed struct for the WB entry {valid, dst, byte, val}.
REQ-034 SHALL implement the byte merge once, in sub-module wb_merge (inputs old[15:0], new[15:0], byte; output merged[15:0]), instantiated for both the commit path and fwd_val_o.

Verification
REQ-035 SHALL cover reset: assert rst mid-write -> R0..R7=0, fwd_valid_o=0, bank 1 = {0,1,2,4,8,16,32,0xFFFF}.
REQ-036 SHALL cover a word write: word write R3=0x1234 -> R3 reads 0x1234 two edges later, and fwd_val_o=0x1234 in between.
REQ-037 SHALL cover a byte write: R2=0xABCD, then byte write 0x0077 -> R2=0xAB77, and the high byte is preserved.
REQ-038 SHALL cover back-to-back byte writes: R1=0x0000, then byte writes 0x11 and 0x22 on consecutive cycles -> R1=0x0022; then word 0x5566 followed by byte 0x99 -> R1=0x5599.
REQ-039 SHALL cover stall and flush:
- R4 write with stall_i=1 for 3 cycles -> R4 unchanged until stall drops, then written;
- flush_i with stall_i -> write never commits.
REQ-040 SHALL cover the PC pulse: word write R7=0x0100 -> pc_load_o high exactly 1 cycle, and R7=0x0100; with WB_BYPASS_EN, gprc shows 0x0100 one edge earlier.
